// File: rtl/tdm_channel_mux.sv
// tdm_channel_mux
//   Registered N-channel multiplexer with manual select and round-robin scan.
//   The selected channel's sample and its index are held in an output register
//   guarded by a valid/ready handshake.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   din        in   N_CH*WIDTH packed channels, channel 0 in the LSBs
//   en         in   enable; 0 stops new captures
//   mode       in   0 = manual (sel), 1 = scan
//   sel        in   manual channel select
//   dout_ready in   consumer accepts dout this cycle
//   dout       out  captured sample
//   dout_ch    out  channel index of dout
//   dout_valid out  dout/dout_ch hold an unaccepted sample
//   sel_err    out  last manual capture attempt had sel >= N_CH
module tdm_channel_mux #(
  parameter int N_CH  = 5,
  parameter int WIDTH = 8,
  parameter int SEL_W = 3,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] din,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  dout_ready,
  output logic [WIDTH-1:0]      dout,
  output logic [SEL_W-1:0]      dout_ch,
  output logic                  dout_valid,
  output logic                  sel_err
);

  localparam int CNT_W = $clog2(DWELL + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAN  = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nx;
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] ptr_nx;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nx;

  logic [WIDTH-1:0] dout_nx;
  logic [SEL_W-1:0] ch_nx;
  logic             valid_nx;
  logic             err_nx;

  logic [WIDTH-1:0] man_sample;
  logic [WIDTH-1:0] scan_sample;
  logic             slot_open;
  logic             accept;
  logic             sel_ok;
  logic             cap_man;
  logic             cap_scan;
  logic             scan_entry;

  // Next FSM state follows en/mode directly; it is registered every edge.
  always_comb begin
    case ({en, mode})
      2'b10:   state_nx = MAN;
      2'b11:   state_nx = SCAN;
      default: state_nx = IDLE;
    endcase
  end

  // AND-OR channel selection; out-of-range indices simply select nothing.
  always_comb begin
    man_sample  = {WIDTH{1'b0}};
    scan_sample = {WIDTH{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      man_sample  = man_sample  | (din[k*WIDTH +: WIDTH] & {WIDTH{sel   == SEL_W'(k)}});
      scan_sample = scan_sample | (din[k*WIDTH +: WIDTH] & {WIDTH{ptr_r == SEL_W'(k)}});
    end
  end

  // Handshake qualifiers and capture conditions.
  always_comb begin
    slot_open  = !dout_valid || dout_ready;
    accept     = dout_valid && dout_ready;
    // Extra MSB keeps the compare correct when 2^SEL_W == N_CH.
    sel_ok     = ({1'b0, sel} < (SEL_W+1)'(N_CH));
    cap_man    = (state_r == MAN)  && slot_open;
    cap_scan   = (state_r == SCAN) && slot_open;
    scan_entry = (state_r != SCAN) && (state_nx == SCAN);
  end

  // Next values of the output register and the scan pointer/dwell counter.
  always_comb begin
    dout_nx  = dout;
    ch_nx    = dout_ch;
    valid_nx = dout_valid;
    err_nx   = sel_err;
    ptr_nx   = ptr_r;
    cnt_nx   = cnt_r;
    if (cap_man && sel_ok) begin
      dout_nx  = man_sample;
      ch_nx    = sel;
      valid_nx = 1'b1;
      err_nx   = 1'b0;
    end else if (cap_man) begin
      // Rejected select: flag it, but still honour an acceptance of the held sample.
      err_nx   = 1'b1;
      valid_nx = accept ? 1'b0 : dout_valid;
    end else if (cap_scan) begin
      dout_nx  = scan_sample;
      ch_nx    = ptr_r;
      valid_nx = 1'b1;
      if (cnt_r == CNT_W'(DWELL - 1)) begin
        cnt_nx = {CNT_W{1'b0}};
        ptr_nx = (ptr_r == SEL_W'(N_CH - 1)) ? {SEL_W{1'b0}} : ptr_r + SEL_W'(1);
      end else begin
        cnt_nx = cnt_r + CNT_W'(1);
      end
    end else begin
      valid_nx = accept ? 1'b0 : dout_valid;
    end
    // Entering scan restarts at channel 0; never coincides with a scan capture.
    if (scan_entry) begin
      ptr_nx = {SEL_W{1'b0}};
      cnt_nx = {CNT_W{1'b0}};
    end else begin
      ptr_nx = ptr_nx;
      cnt_nx = cnt_nx;
    end
  end

  // State, scan counters and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= {SEL_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      dout       <= {WIDTH{1'b0}};
      dout_ch    <= {SEL_W{1'b0}};
      dout_valid <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      state_r    <= state_nx;
      ptr_r      <= ptr_nx;
      cnt_r      <= cnt_nx;
      dout       <= dout_nx;
      dout_ch    <= ch_nx;
      dout_valid <= valid_nx;
      sel_err    <= err_nx;
    end
  end

endmodule

// File: tb/tb_tdm_channel_mux.sv
// tb_tdm_channel_mux
//   Directed and randomized stimulus for tdm_channel_mux (N_CH=5, WIDTH=8,
//   SEL_W=3, DWELL=2). Expected values come from a slot-count reference model:
//   in scan mode the k-th capture since scan entry is channel (k / DWELL) % N_CH.
module tb_tdm_channel_mux;

  localparam int N_CH  = 5;
  localparam int WIDTH = 8;
  localparam int SEL_W = 3;
  localparam int DWELL = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH*WIDTH-1:0] din;
  logic                  en;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic                  dout_ready;
  logic [WIDTH-1:0]      dout;
  logic [SEL_W-1:0]      dout_ch;
  logic                  dout_valid;
  logic                  sel_err;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int             m_state;   // 0 idle, 1 manual, 2 scan
  int             m_k;       // scan captures since scan entry
  logic [WIDTH-1:0] m_dout;
  logic [SEL_W-1:0] m_ch;
  logic           m_valid;
  logic           m_err;

  tdm_channel_mux #(.N_CH(N_CH), .WIDTH(WIDTH), .SEL_W(SEL_W), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .din(din), .en(en), .mode(mode), .sel(sel),
    .dout_ready(dout_ready), .dout(dout), .dout_ch(dout_ch),
    .dout_valid(dout_valid), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // Model the effect of one rising edge given the currently driven inputs.
  task automatic model_edge();
    int ns;
    int ch;
    bit open;
    bit acc;
    if (rst) begin
      m_state = 0; m_k = 0; m_dout = '0; m_ch = '0; m_valid = 1'b0; m_err = 1'b0;
    end else begin
      open = !m_valid || dout_ready;
      acc  = m_valid && dout_ready;
      ns   = !en ? 0 : (mode ? 2 : 1);
      if (m_state == 1 && open) begin
        if (int'(sel) < N_CH) begin
          m_dout = din[int'(sel)*WIDTH +: WIDTH]; m_ch = sel; m_valid = 1'b1; m_err = 1'b0;
        end else begin
          m_err = 1'b1;
          if (acc) m_valid = 1'b0;
        end
      end else if (m_state == 2 && open) begin
        ch = (m_k / DWELL) % N_CH;
        m_dout = din[ch*WIDTH +: WIDTH]; m_ch = SEL_W'(ch); m_valid = 1'b1;
        m_k++;
      end else if (acc) begin
        m_valid = 1'b0;
      end
      if (ns == 2 && m_state != 2) m_k = 0;
      m_state = ns;
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then compare every output with the model.
  task automatic step(string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".dout"},  int'(dout),       int'(m_dout));
    chk({tag, ".ch"},    int'(dout_ch),    int'(m_ch));
    chk({tag, ".valid"}, int'(dout_valid), int'(m_valid));
    chk({tag, ".err"},   int'(sel_err),    int'(m_err));
  endtask

  task automatic set_ramp();
    for (int k = 0; k < N_CH; k++) din[k*WIDTH +: WIDTH] = WIDTH'(8'h10 + k);
  endtask

  int seq [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};
  int guard;

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; dout_ready = 1'b0; din = '0;
    m_state = 0; m_k = 0; m_dout = '0; m_ch = '0; m_valid = 1'b0; m_err = 1'b0;
    step("reset0");
    step("reset1");
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_dout",  int'(dout), 0);

    // Manual capture latency
    rst = 1'b0; en = 1'b1; mode = 1'b0; sel = 3'd3; dout_ready = 1'b1;
    din = '0; din[3*WIDTH +: WIDTH] = 8'hA5;
    step("man_e");
    chk("man_lat_e", int'(dout_valid), 0);
    step("man_e1");
    chk("man_lat_valid", int'(dout_valid), 1);
    chk("man_lat_dout",  int'(dout), 8'hA5);
    chk("man_lat_ch",    int'(dout_ch), 3);

    // Out-of-range select
    sel = 3'd6;
    for (int i = 0; i < 3; i++) step("badsel");
    chk("badsel_err",   int'(sel_err), 1);
    chk("badsel_valid", int'(dout_valid), 0);
    chk("badsel_hold",  int'(dout), 8'hA5);
    sel = 3'd0; din[0 +: WIDTH] = 8'h3C;
    step("sel0");
    chk("sel0_err",  int'(sel_err), 0);
    chk("sel0_dout", int'(dout), 8'h3C);

    // Scan sequence with wrap
    set_ramp();
    mode = 1'b1;
    step("scan_entry");
    for (int i = 0; i < 12; i++) begin
      step("scan_seq");
      chk("scan_seq_ch",   int'(dout_ch), seq[i]);
      chk("scan_seq_dout", int'(dout), 8'h10 + seq[i]);
    end

    // Mid-dwell backpressure
    step("pre_stall");
    dout_ready = 1'b0;
    for (int i = 0; i < 5; i++) step("stall");
    dout_ready = 1'b1;
    for (int i = 0; i < 6; i++) step("resume");

    // Scan -> manual -> scan
    mode = 1'b0; sel = 3'd2;
    for (int i = 0; i < 3; i++) step("to_man");
    chk("to_man_ch", int'(dout_ch), 2);
    mode = 1'b1;
    step("reenter");
    step("reenter_first");
    chk("reenter_ch", int'(dout_ch), 0);

    // Reset with ptr at channel 3
    guard = 0;
    while (!(m_valid && m_ch == 3'd3) && guard < 40) begin
      step("to_ch3");
      guard++;
    end
    chk("reach_ch3", guard < 40 ? 1 : 0, 1);
    rst = 1'b1;
    step("mid_rst");
    chk("mid_rst_valid", int'(dout_valid), 0);
    chk("mid_rst_ch",    int'(dout_ch), 0);
    chk("mid_rst_dout",  int'(dout), 0);
    rst = 1'b0;
    step("post_rst_e");
    step("post_rst_first");
    chk("post_rst_ch", int'(dout_ch), 0);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      rst        = ($urandom_range(0, 99) < 2);
      en         = ($urandom_range(0, 9) != 0);
      mode       = ($urandom_range(0, 7) != 0) ? mode : ~mode;
      sel        = SEL_W'($urandom_range(0, 7));
      dout_ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N_CH; k++) din[k*WIDTH +: WIDTH] = WIDTH'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
